// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM data port between NUM_MASTERS OBI-style requesters.
// Optional build macro RAM_ARB_RANDOM_STALL_EN adds LFSR-driven grant suppression.
module ram_port_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_MASTERS-1:0]       req_i,
  output logic [NUM_MASTERS-1:0]       gnt_o,
  input  logic [NUM_MASTERS-1:0][31:0] addr_i,
  input  logic [NUM_MASTERS-1:0]       we_i,
  input  logic [NUM_MASTERS-1:0][3:0]  be_i,
  input  logic [NUM_MASTERS-1:0][31:0] wdata_i,
  output logic [NUM_MASTERS-1:0]       rvalid_o,
  output logic [NUM_MASTERS-1:0]       err_o,
  output logic [NUM_MASTERS-1:0][31:0] rdata_o,
  output logic                         ram_en_o,
  output logic [ADDR_WIDTH-1:0]        ram_addr_o,
  output logic                         ram_we_o,
  output logic [3:0]                   ram_be_o,
  output logic [31:0]                  ram_wdata_o,
  input  logic [31:0]                  ram_rdata_i
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W:0] NM = (IDX_W+1)'(NUM_MASTERS);

  logic [IDX_W-1:0]       prio_q, prio_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;
  logic                   rd_ok_q, rd_ok_d;

  logic                   stall_s;
  logic                   grant_s;
  logic [IDX_W-1:0]       win_s;
  logic [IDX_W:0]         cand_s;
  logic [IDX_W:0]         nxt_s;
  logic                   in_range_s;

`ifdef RAM_ARB_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign stall_s = (lfsr_q[1:0] == 2'b00);

  // Free-running stall generator, advances every cycle out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end
`else
  assign stall_s = 1'b0;
`endif

  // Winner search starting at prio_q, wrapping around the master count
  always_comb begin
    grant_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_s = {1'b0, prio_q} + (IDX_W+1)'(i);
      if (cand_s >= NM) begin
        cand_s = cand_s - NM;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_s && req_i[cand_s[IDX_W-1:0]]) begin
        grant_s = 1'b1;
        win_s   = cand_s[IDX_W-1:0];
      end else begin
        grant_s = grant_s;
      end
    end
    if (stall_s || !rst_ni) begin
      grant_s = 1'b0;
    end else begin
      grant_s = grant_s;
    end
  end

  assign in_range_s = ((addr_i[win_s] >> ADDR_WIDTH) == 32'd0);

  // Grant and RAM port drive; out-of-range winners are granted but never touch the RAM
  always_comb begin
    gnt_o       = '0;
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'b0000;
    ram_wdata_o = 32'd0;
    if (grant_s) begin
      gnt_o[win_s] = 1'b1;
      if (in_range_s) begin
        ram_en_o    = 1'b1;
        ram_addr_o  = addr_i[win_s][ADDR_WIDTH-1:0];
        ram_we_o    = we_i[win_s];
        ram_be_o    = be_i[win_s];
        ram_wdata_o = wdata_i[win_s];
      end else begin
        ram_en_o = 1'b0;
      end
    end else begin
      gnt_o = '0;
    end
  end

  // Pointer advance and response capture for the current winner
  always_comb begin
    prio_d   = prio_q;
    owner_d  = owner_q;
    rvalid_d = '0;
    err_d    = '0;
    rd_ok_d  = 1'b0;
    nxt_s    = {1'b0, win_s} + (IDX_W+1)'(1);
    if (grant_s) begin
      if (nxt_s >= NM) begin
        prio_d = '0;
      end else begin
        prio_d = nxt_s[IDX_W-1:0];
      end
      owner_d         = win_s;
      rvalid_d[win_s] = 1'b1;
      err_d[win_s]    = !in_range_s;
      rd_ok_d         = in_range_s && !we_i[win_s];
    end else begin
      prio_d = prio_q;
    end
  end

  // Arbitration and response state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q   <= '0;
      owner_q  <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rd_ok_q  <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_ok_q  <= rd_ok_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

  // RAM read data is already registered in the RAM, so only the owner gate is applied here
  always_comb begin
    rdata_o = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (rd_ok_q && (owner_q == IDX_W'(m))) begin
        rdata_o[m] = ram_rdata_i;
      end else begin
        rdata_o[m] = 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios plus random traffic against a
// behavioural model of round-robin order, word memory and (when enabled) the stall LFSR.
module tb_ram_port_arbiter;
  localparam int N     = 2;
  localparam int AW    = 8;
  localparam int WORDS = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       req, gnt, we, rvalid, err;
  logic [N-1:0][31:0] addr, wdata, rdata;
  logic [N-1:0][3:0]  be;
  logic               ram_en, ram_we;
  logic [AW-1:0]      ram_addr;
  logic [3:0]         ram_be;
  logic [31:0]        ram_wdata, ram_rdata;
  logic               clr = 1'b1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          m;
    bit          e;
    logic [31:0] d;
    time         t;
  } resp_t;
  resp_t exp_q[$];

  int          ref_prio = 0;
  logic [31:0] ref_mem [WORDS];
  logic [15:0] ref_lfsr = 16'hACE1;
  int          age [N];

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .err_o(err), .rdata_o(rdata),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Word-organised test RAM with registered read
  logic [31:0] bram [WORDS];
  always @(posedge clk) begin
    if (clr) begin
      for (int w = 0; w < WORDS; w++) bram[w] <= 32'd0;
    end else if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) bram[ram_addr[AW-1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= bram[ram_addr[AW-1:2]];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT strobes rvalid
  always @(negedge clk) begin
    resp_t e;
    logic [N-1:0]       ev, ee;
    logic [N-1:0][31:0] ed;
    if (rvalid !== '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 64'(rvalid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        ev = '0; ee = '0; ed = '0;
        ev[e.m] = 1'b1;
        ee[e.m] = e.e;
        ed[e.m] = e.d;
        chk("resp_latency", 64'($time), 64'(e.t + 10));
        chk("rvalid", 64'(rvalid), 64'(ev));
        chk("err", 64'(err), 64'(ee));
        chk("rdata", 64'(rdata), 64'(ed));
      end
    end else if (exp_q.size() > 0 && (exp_q[0].t + 10 <= $time)) begin
      e = exp_q.pop_front();
      chk("missing_rvalid", 64'(rvalid), 64'(1 << e.m));
    end
  end

  task automatic put(input int m, input bit w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    req[m] = 1'b1; we[m] = w; addr[m] = a; be[m] = b; wdata[m] = d;
  endtask

  // One clock of stimulus: predict the winner, check grant/RAM port, queue the response
  task automatic step();
    int           w;
    bit           stall, oor;
    logic [N-1:0] eg;
    int           wi;
    resp_t        r;
    @(negedge clk);
    stall = 1'b0;
`ifdef RAM_ARB_RANDOM_STALL_EN
    stall = (ref_lfsr[1:0] == 2'b00);
`endif
    w = -1;
    if (!stall) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(ref_prio + k) % N]) w = (ref_prio + k) % N;
      end
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", 64'(gnt), 64'(eg));
    if (w >= 0) begin
      oor = (addr[w] >> AW) != 32'd0;
      wi  = int'(addr[w] >> 2) % WORDS;
      chk("ram_en", 64'(ram_en), 64'(!oor));
      if (!oor) begin
        chk("ram_fields", 64'({ram_addr, ram_we, ram_be, ram_wdata}),
            64'({addr[w][AW-1:0], we[w], be[w], wdata[w]}));
      end else begin
        chk("ram_oor_idle", 64'({ram_addr, ram_we, ram_be, ram_wdata}), 64'd0);
      end
      r.m = w; r.e = oor; r.t = $time;
      r.d = (oor || we[w]) ? 32'd0 : ref_mem[wi];
      exp_q.push_back(r);
      if (!oor && we[w]) begin
        for (int b = 0; b < 4; b++)
          if (be[w][b]) ref_mem[wi][8*b +: 8] = wdata[w][8*b +: 8];
      end
      ref_prio = (w + 1) % N;
    end else begin
      chk("ram_idle", 64'({ram_en, ram_addr, ram_we, ram_be, ram_wdata}), 64'd0);
    end
    @(posedge clk);
    #1;
    if (w >= 0) req[w] = 1'b0;
`ifdef RAM_ARB_RANDOM_STALL_EN
    ref_lfsr = {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
`endif
    for (int m = 0; m < N; m++) begin
      age[m] = req[m] ? age[m] + 1 : 0;
      if (age[m] > 40) begin
        chk("starved_request", 64'(m), 64'(-1));
        req[m] = 1'b0;
        age[m] = 0;
      end
    end
  endtask

  task automatic run(input int maxc);
    int c;
    c = 0;
    while (req != '0 && c < maxc) begin
      step();
      c++;
    end
    if (req != '0) begin
      chk("grant_timeout", 64'(req), 64'd0);
      req = '0;
    end
    step();
  endtask

  initial begin
    int          issued, guard;
    logic [31:0] a;
    req = '0; we = '0; addr = '0; be = '0; wdata = '0;
    for (int w = 0; w < WORDS; w++) ref_mem[w] = 32'd0;
    for (int m = 0; m < N; m++) age[m] = 0;

    // Reset state, with a live request that must not be granted
    put(0, 1'b1, 32'h10, 4'hF, 32'hCAFE_F00D);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_ram", 64'({ram_en, ram_addr, ram_we, ram_be, ram_wdata}), 64'd0);
    chk("rst_resp", 64'({rvalid, err}), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk);
    #1;
    req = '0;
    clr = 1'b0;
    rst_n = 1'b1;

    // Single-master write then read
    put(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF); run(20);
    put(0, 1'b0, 32'h10, 4'h0, 32'h0);         run(20);
    // Byte enables over an all-ones word
    put(0, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF); run(20);
    put(0, 1'b1, 32'h20, 4'b0101, 32'h1122_3344); run(20);
    put(0, 1'b0, 32'h20, 4'h0, 32'h0);         run(20);
    // Out-of-range read from master 1
    put(1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);  run(20);
    // Both masters requesting continuously
    for (int c = 0; c < 6; c++) begin
      for (int m = 0; m < N; m++)
        if (!req[m]) put(m, 1'b0, 32'(m * 4 + 16), 4'hF, 32'h0);
      step();
    end
    run(20);
    repeat (2) step();

    // Reset asserted in a grant cycle: the grant and its response vanish
    put(1, 1'b0, 32'h10, 4'hF, 32'h0);
    #2;
    rst_n = 1'b0;
    ref_prio = 0;
    ref_lfsr = 16'hACE1;
    @(negedge clk);
    chk("rst_mid_gnt", 64'(gnt), 64'd0);
    chk("rst_mid_ram", 64'({ram_en, ram_addr, ram_we, ram_be, ram_wdata}), 64'd0);
    chk("rst_mid_resp", 64'({rvalid, err, rdata}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    put(0, 1'b0, 32'h20, 4'hF, 32'h0);
    run(20);
    repeat (2) step();

    // Random traffic from all masters
    issued = 0;
    guard  = 0;
    while (issued < 1000 && guard < 20000) begin
      for (int m = 0; m < N; m++) begin
        if (!req[m] && issued < 1000 && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 9) == 0) a = ($urandom | 32'h0000_0100) & 32'hFFFF_FFFC;
          else a = 32'($urandom_range(0, 15)) << 2;
          put(m, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
          issued++;
        end
      end
      step();
      guard++;
    end
    chk("random_issued", 64'(issued), 64'd1000);
    run(100);
    repeat (2) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
